// File: rtl/sim_time_gen_pkg.sv
// Shared constants for the simulation time base and its status readout.
`ifndef WIDTH_TIME
`define WIDTH_TIME 32
`endif

package sim_time_gen_pkg;

    // Default width of the step index, taken from the global width macro.
    localparam int WIDTH_TIME_DEF = `WIDTH_TIME;

    // Width of the overrun event counter; status readout sizes its field from this.
    localparam int OVR_CNT_W = 16;

    localparam logic [OVR_CNT_W-1:0] OVR_CNT_MAX = {OVR_CNT_W{1'b1}};

endpackage

// File: rtl/sim_time_gen_if.sv
// Step launch / solver handshake and status bundle of the time base.
interface sim_time_gen_if
    import sim_time_gen_pkg::*;
#(
    parameter int WIDTH_TIME = WIDTH_TIME_DEF
);

    logic                  run;
    logic                  step_done;
    logic [WIDTH_TIME-1:0] sim_time;
    logic                  step_start;
    logic                  init_phase;
    logic                  busy;
    logic                  overrun;
    logic [OVR_CNT_W-1:0]  overrun_cnt;
    logic                  halted;

    modport master (
        input  run, step_done,
        output sim_time, step_start, init_phase, busy, overrun, overrun_cnt, halted
    );

    modport slave (
        output run, step_done,
        input  sim_time, step_start, init_phase, busy, overrun, overrun_cnt, halted
    );

endinterface

// File: rtl/sim_time_gen_step_timer.sv
// Modulo-STEP_CYCLES tick counter with synchronous clear and expiry flag.
module step_timer #(
    parameter int STEP_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int               CNT_W = $clog2(STEP_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Count ticks within the current step; clear wins over counting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign expire = (cnt == LAST);

endmodule

// File: rtl/sim_time_gen.sv
// Real-time step launcher: paces solver steps, tracks the done handshake,
// flags overruns and reports the initialisation phase.
module sim_time_gen
    import sim_time_gen_pkg::*;
#(
    parameter int WIDTH_TIME  = WIDTH_TIME_DEF,
    parameter int STEP_CYCLES = 1000,
    parameter int INIT_STEPS  = 10000,
    parameter int STOP_TIME   = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    sim_time_gen_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic                  expire;
    logic                  timer_en;
    logic                  launch;
    logic                  ovr_evt;
    logic                  stop_hit;
    logic                  launched;
    logic [WIDTH_TIME-1:0] launch_time;

    logic [WIDTH_TIME-1:0] sim_time_q;
    logic                  step_start_q;
    logic                  init_phase_q;
    logic                  busy_q;
    logic                  overrun_q;
    logic [OVR_CNT_W-1:0]  overrun_cnt_q;
    logic                  halted_q;

    function automatic logic [OVR_CNT_W-1:0] sat_inc(input logic [OVR_CNT_W-1:0] v);
        return (v == OVR_CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign timer_en = (state == ST_RUN);

    step_timer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (launch),
        .en     (timer_en),
        .expire (expire)
    );

    // Compare in 64 bits so limits wider than the index never alias.
    assign stop_hit = (STOP_TIME != 0) && (64'(sim_time_q) == 64'(STOP_TIME));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state: stop check takes priority over pausing at expiry.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.run) state_nxt = ST_RUN;
            ST_RUN: begin
                if (expire) begin
                    if (stop_hit)     state_nxt = ST_HALT;
                    else if (!bus.run) state_nxt = ST_IDLE;
                end
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: launch decision, index of the launched step, overrun event.
    always_comb begin
        launch      = 1'b0;
        ovr_evt     = 1'b0;
        launch_time = sim_time_q + 1'b1;
        case (state)
            ST_IDLE: begin
                launch = bus.run;
                // The very first step after reset is step 0, resumes continue.
                if (!launched) launch_time = '0;
            end
            ST_RUN: begin
                if (expire) begin
                    // A done pulse coinciding with expiry is still on time.
                    ovr_evt = busy_q && !bus.step_done;
                    launch  = !stop_hit && bus.run;
                end
            end
            default: ;
        endcase
    end

    // Launch bookkeeping, handshake tracking and sticky status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sim_time_q    <= '0;
            step_start_q  <= 1'b0;
            init_phase_q  <= 1'b1;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            overrun_cnt_q <= '0;
            halted_q      <= 1'b0;
            launched      <= 1'b0;
        end else begin
            step_start_q <= launch;
            if (launch) begin
                launched     <= 1'b1;
                sim_time_q   <= launch_time;
                // Once cleared it never returns, even across an index wrap.
                init_phase_q <= init_phase_q && (64'(launch_time) <= 64'(INIT_STEPS));
            end
            if (launch)             busy_q <= 1'b1;
            else if (bus.step_done) busy_q <= 1'b0;
            if (ovr_evt) begin
                overrun_q     <= 1'b1;
                overrun_cnt_q <= sat_inc(overrun_cnt_q);
            end
            if (state == ST_RUN && state_nxt == ST_HALT) halted_q <= 1'b1;
        end
    end

    assign bus.sim_time    = sim_time_q;
    assign bus.step_start  = step_start_q;
    assign bus.init_phase  = init_phase_q;
    assign bus.busy        = busy_q;
    assign bus.overrun     = overrun_q;
    assign bus.overrun_cnt = overrun_cnt_q;
    assign bus.halted      = halted_q;

endmodule

// File: tb/tb_sim_time_gen.sv
// Directed bench for sim_time_gen with STEP_CYCLES=8, INIT_STEPS=3, STOP_TIME=6.
// Cycle c is observed 1 time unit after the c-th rising edge following reset
// release; inputs set at cycle c are sampled at edge c+1.
module tb_sim_time_gen;
    import sim_time_gen_pkg::*;

    typedef struct {
        int   scn;
        int   cyc;
        logic ss;
        int   t;
        logic busy;
        logic ov;
        int   cnt;
        logic halt;
        logic init;
    } vec_t;

    vec_t vecs[$];

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    sim_time_gen_if #(.WIDTH_TIME(32)) bus ();

    sim_time_gen #(
        .WIDTH_TIME  (32),
        .STEP_CYCLES (8),
        .INIT_STEPS  (3),
        .STOP_TIME   (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic vec_t mk(int scn, int cyc, logic ss, int t, logic busy,
                                logic ov, int cnt, logic halt, logic init);
        vec_t v;
        v.scn = scn; v.cyc = cyc; v.ss = ss; v.t = t; v.busy = busy;
        v.ov = ov; v.cnt = cnt; v.halt = halt; v.init = init;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.run = 1'b0;
        bus.step_done = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Per-scenario input pattern as a function of the cycle number.
    task automatic drive(int scn, int c);
        logic r, d, n;
        r = 1'b1;
        d = (c % 8 == 3);
        n = 1'b1;
        case (scn)
            1: d = (c % 8 == 3) && (c != 19);                 // withhold done of step 2
            2: d = ((c % 8 == 3) && (c != 11)) || (c == 16);  // step 1 done at its expiry
            3: r = (c < 12) || (c >= 30);                     // pause and resume
            4: n = (c != 28);                                 // reset mid step 3
            5: begin                                          // spurious done in IDLE
                r = (c >= 8);
                d = (c == 2);
                n = (c != 5);
            end
            default: ;
        endcase
        bus.run = r;
        bus.step_done = d;
        rst_n = n;
    endtask

    task automatic check_rows(int scn, int c);
        foreach (vecs[i]) begin
            if (vecs[i].scn == scn && vecs[i].cyc == c) begin
                n_tests++;
                if (bus.step_start !== vecs[i].ss || bus.sim_time !== 32'(vecs[i].t) ||
                    bus.busy !== vecs[i].busy || bus.overrun !== vecs[i].ov ||
                    bus.overrun_cnt !== 16'(vecs[i].cnt) || bus.halted !== vecs[i].halt ||
                    bus.init_phase !== vecs[i].init) begin
                    n_fail++;
                    $display("FAIL scn%0d_cyc%0d: got ss=%b t=%0d busy=%b ov=%b cnt=%0d halt=%b init=%b, want ss=%b t=%0d busy=%b ov=%b cnt=%0d halt=%b init=%b",
                             scn, c, bus.step_start, bus.sim_time, bus.busy, bus.overrun,
                             bus.overrun_cnt, bus.halted, bus.init_phase,
                             vecs[i].ss, vecs[i].t, vecs[i].busy, vecs[i].ov,
                             vecs[i].cnt, vecs[i].halt, vecs[i].init);
                end
            end
        end
    endtask

    initial begin
        int len[6];
        len = '{66, 29, 21, 40, 31, 10};

        //                 scn cyc ss  t  busy ov cnt halt init
        // Normal run, solver answers 2 cycles after each start, stops after step 6.
        vecs.push_back(mk(0,  0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0,  1, 1, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0,  2, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0,  4, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0,  8, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0,  9, 1, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 17, 1, 2, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 25, 1, 3, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 33, 1, 4, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 49, 1, 6, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 56, 0, 6, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 57, 0, 6, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 65, 0, 6, 0, 0, 0, 1, 0));
        // Overrun on step 2: step 3 still launches, busy stays high.
        vecs.push_back(mk(1, 24, 0, 2, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 25, 1, 3, 1, 1, 1, 0, 1));
        vecs.push_back(mk(1, 28, 0, 3, 0, 1, 1, 0, 1));
        // Done coinciding with expiry is on time.
        vecs.push_back(mk(2, 16, 0, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk(2, 17, 1, 2, 1, 0, 0, 0, 1));
        vecs.push_back(mk(2, 20, 0, 2, 0, 0, 0, 0, 1));
        // Pause: no launch at 17, index holds; resume launches the next index.
        vecs.push_back(mk(3, 17, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(3, 30, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(3, 31, 1, 2, 1, 0, 0, 0, 1));
        vecs.push_back(mk(3, 39, 1, 3, 1, 0, 0, 0, 1));
        // Reset mid step 3, then restart from step 0.
        vecs.push_back(mk(4, 28, 0, 3, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4, 29, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4, 30, 1, 0, 1, 0, 0, 0, 1));
        // Spurious done in IDLE is ignored; reset pulse; first launch is step 0.
        vecs.push_back(mk(5,  3, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(5,  6, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(5,  9, 1, 0, 1, 0, 0, 0, 1));

        for (int s = 0; s < 6; s++) begin
            do_reset();
            for (int c = 0; c < len[s]; c++) begin
                check_rows(s, c);
                drive(s, c);
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sim_time_gen.md
# sim_time_gen

Real-time simulation time base: the producer of the `sim_time` step index that downstream start/run selectors compare against a threshold, such as initial-value vs. computed-value muxes. It launches one solver step every `STEP_CYCLES` clocks with a single-cycle `step_start` pulse and tracks the solver's `step_done` handshake. It flags real-time overruns and raises `init_phase` while `sim_time <= INIT_STEPS`. It sits at the top of the wind-turbine RTS datapath and fans out to every time-dependent block.

## Interface
- `WIDTH_TIME`, default `` `WIDTH_TIME `` (global): width of `sim_time`.
- `STEP_CYCLES`, default 1000: clocks per simulation step; must be ≥ 2.
- `INIT_STEPS`, default 10000: last step index treated as the initialisation phase.
- `STOP_TIME`, default 0: last step index to launch; 0 means free-running.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `run`  in  1  level; enables step launching.
- `step_done`  in  1  one-cycle pulse from the solver when the current step completes.
- `sim_time`  out  `WIDTH_TIME`  index of the step currently being solved; registered.
- `step_start`  out  1  one-cycle pulse, coincident with the `sim_time` update.
- `init_phase`  out  1  high while `sim_time <= INIT_STEPS`; registered.
- `busy`  out  1  a step is launched and `step_done` has not yet been seen.
- `overrun`  out  1  sticky; a period expired while `busy`.
- `overrun_cnt`  out  16  saturating count of overrun events.
- `halted`  out  1  `STOP_TIME` reached; no further launches.

## Operation
- Reset values: `sim_time`=0, `step_start`=0, `init_phase`=1, `busy`=0, `overrun`=0, `overrun_cnt`=0, `halted`=0. FSM enters IDLE and the tick counter is 0. Reset taken mid-step discards everything.
- FSM states: IDLE, RUN, HALT.
- IDLE -> RUN when `run`=1, with a launch on the same edge:
  - First launch after reset uses `sim_time`=0.
  - A launch after a pause uses `sim_time`+1.
- RUN:
  - Tick counter clears at each launch and increments every cycle.
  - Expiry: counter == `STEP_CYCLES`-1.
  - At expiry, if `STOP_TIME`≠0 and `sim_time`==`STOP_TIME`, go to HALT and set `halted`=1.
  - Otherwise, at expiry with `run`=1, launch the next step (`sim_time`+1).
  - Otherwise, at expiry with `run`=0, go to IDLE; `sim_time` holds.
- HALT: absorbing until reset. `step_done` still clears `busy`.
- Launch actions, all on one edge: `step_start`=1, `sim_time` updated, `busy`=1, tick counter=0.
- `step_done` while `busy` clears `busy`. `step_done` while not `busy` is ignored.
- Overrun: at expiry with `busy`=1, whether or not a launch follows:
  - Set `overrun`.
  - Increment `overrun_cnt`, saturating at 0xFFFF.
  - Still launch the next step when launch conditions hold; real-time pacing has priority.
- `step_done` in the same cycle as expiry counts as on-time: no overrun, and `busy` is set for the new step.
- `init_phase`:
  - Register the result of `sim_time <= INIT_STEPS` on the edge of the `sim_time` update.
  - Once it falls, it stays 0 until reset, including after a free-running `sim_time` wrap from all-ones to 0.
- `sim_time` wraps modulo 2^`WIDTH_TIME` when free-running. There is no wrap flag.

## Timing
- `run` sampled high in IDLE: `step_start` appears on the next edge (1-cycle latency).
- Step period is exactly `STEP_CYCLES` clocks, `step_start` to `step_start`, while `run` stays high.
- `busy` falls on the edge after `step_done` is sampled.
- `overrun`, `overrun_cnt`, `halted` and `init_phase` update on the same edge as the corresponding expiry or launch.
- Deasserting `run` mid-period does not truncate the period. No launch occurs at that period's expiry.

## Structure
- Shared include (`global_parameter.v`) supplies `` `WIDTH_TIME ``. FSM state encodings are local parameters of this block. The overrun counter width (16) is a shared constant, so status readout can use it.
- One sub-module, `step_timer`:
  - Parameterised modulo-`STEP_CYCLES` counter with a synchronous clear.
  - `expire` output, combinational on counter == `STEP_CYCLES`-1.
  - The FSM, handshake and status logic stay in `sim_time_gen`.

## Test plan
Bench parameters: `STEP_CYCLES`=8, `INIT_STEPS`=3, `STOP_TIME`=6.

- Reset, then `run`=1 at cycle 0, solver answers 2 cycles after each start:
  - `step_start` at cycles 1, 9, 17, …; `sim_time` = 0, 1, 2, ….
  - `init_phase` falls with `sim_time`=4.
  - `halted`=1 at the expiry of step 6 (cycle 56); no further `step_start`.
- Withhold `step_done` for step 2:
  - At cycle 25, `overrun`=1 and `overrun_cnt`=1.
  - Step 3 still launches at cycle 25 and `busy` stays 1.
- `step_done` exactly at the expiry cycle of step 1: `overrun`=0, and `busy`=1 for step 2.
- Drop `run` at cycle 12: no launch at cycle 17, `sim_time` holds 1. Raise `run` at cycle 30: `step_start` at cycle 31 with `sim_time`=2.
- Assert `rst_n`=0 mid-step 3 for one cycle: all outputs at reset values on the next edge, and `init_phase`=1.
- Spurious `step_done` in IDLE, then pulse `rst_n` low: no state change, `busy` stays 0.
